sisc_rf: RTL and testbench

- 16 x 32-bit register file for the SISC datapath.
- Sits directly downstream of the 4-bit register-address select mux, which drives read port B (rb/rd field select).
- Two combinational read ports and one synchronous write port.
- A per-register busy scoreboard lets the control unit stall on reads of registers with pending writes.
- R0 is hardwired to zero.

---
 rtl/sisc_pkg.sv | 16 +
 rtl/sisc_rf_scoreboard.sv | 50 +++++
 rtl/sisc_rf.sv | 87 ++++++++
 tb/tb_sisc_rf.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared constants and types for the SISC register file.
package sisc_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int R0_IDX   = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  function automatic logic is_r0(input reg_addr_t addr);
    return addr == reg_addr_t'(R0_IDX);
  endfunction

endpackage

// File: rtl/sisc_rf_scoreboard.sv
// Per-register busy bits for the SISC register file; a same-register set wins
// over a clear in the same cycle, and entry 0 never becomes busy.
module sisc_rf_scoreboard
  import sisc_pkg::*;
#(
  parameter int ADDR_W = sisc_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_f,
  input  logic                     set_en_i,
  input  logic [ADDR_W-1:0]        set_reg_i,
  input  logic                     clr_en_i,
  input  logic [ADDR_W-1:0]        clr_reg_i,
  input  logic [ADDR_W-1:0]        look_a_i,
  input  logic [ADDR_W-1:0]        look_b_i,
  output logic                     busy_a_o,
  output logic                     busy_b_o,
  output logic [(1<<ADDR_W)-1:0]   busy_vec_o
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) begin
      busy_d[clr_reg_i] = 1'b0;
    end
    // Applied after the clear: a newer writer to the same destination stays pending.
    if (set_en_i && (set_reg_i != '0)) begin
      busy_d[set_reg_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_a_o   = busy_q[look_a_i];
  assign busy_b_o   = busy_q[look_b_i];
  assign busy_vec_o = busy_q;

endmodule

// File: rtl/sisc_rf.sv
// 16x32 SISC register file: two combinational read ports, one write port,
// busy scoreboard. Optional same-cycle write bypass: SISC_RF_WRITE_BYPASS_EN.
module sisc_rf
  import sisc_pkg::*;
#(
  parameter int DATA_W = sisc_pkg::DATA_W,
  parameter int ADDR_W = sisc_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_f,
  input  logic [ADDR_W-1:0]        read_rega,
  input  logic [ADDR_W-1:0]        read_regb,
  output logic [DATA_W-1:0]        rsa,
  output logic [DATA_W-1:0]        rsb,
  input  logic                     rf_we,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     mark_busy,
  input  logic [ADDR_W-1:0]        mark_reg,
  output logic                     stall,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_en;
  logic              busy_a;
  logic              busy_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  assign wr_en = rf_we && (write_reg != '0);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[write_reg] <= write_data;
    end
  end

  always_comb begin
    rd_a = regs_q[read_rega];
    rd_b = regs_q[read_regb];
`ifdef SISC_RF_WRITE_BYPASS_EN
    if (wr_en && (write_reg == read_rega)) begin
      rd_a = write_data;
    end
    if (wr_en && (write_reg == read_regb)) begin
      rd_b = write_data;
    end
`endif
    rsa = (read_rega == '0) ? '0 : rd_a;
    rsb = (read_regb == '0) ? '0 : rd_b;
  end

  sisc_rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_f      (rst_f),
    .set_en_i   (mark_busy),
    .set_reg_i  (mark_reg),
    .clr_en_i   (rf_we),
    .clr_reg_i  (write_reg),
    .look_a_i   (read_rega),
    .look_b_i   (read_regb),
    .busy_a_o   (busy_a),
    .busy_b_o   (busy_b),
    .busy_vec_o (busy_vec)
  );

`ifdef SISC_RF_WRITE_BYPASS_EN
  // A port being written this cycle already sees its new value, so it no longer waits.
  logic byp_a;
  logic byp_b;
  assign byp_a = wr_en && (write_reg == read_rega);
  assign byp_b = wr_en && (write_reg == read_regb);
  assign stall = (busy_a && !byp_a) || (busy_b && !byp_b);
`else
  assign stall = busy_a || busy_b;
`endif

endmodule

// File: tb/tb_sisc_rf.sv
// Randomised bench for sisc_rf against an array-based reference model.
module tb_sisc_rf;

`ifdef SISC_RF_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_f;
  logic [3:0]  read_rega;
  logic [3:0]  read_regb;
  logic [31:0] rsa;
  logic [31:0] rsb;
  logic        rf_we;
  logic [3:0]  write_reg;
  logic [31:0] write_data;
  logic        mark_busy;
  logic [3:0]  mark_reg;
  logic        stall;
  logic [15:0] busy_vec;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_regs [16];
  bit          m_busy [16];

  sisc_rf dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .read_rega  (read_rega),
    .read_regb  (read_regb),
    .rsa        (rsa),
    .rsb        (rsb),
    .rf_we      (rf_we),
    .write_reg  (write_reg),
    .write_data (write_data),
    .mark_busy  (mark_busy),
    .mark_reg   (mark_reg),
    .stall      (stall),
    .busy_vec   (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    if (a == 4'd0) return 32'h0;
    if (BYP && rf_we && write_reg == a) return write_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_port_busy(input logic [3:0] a);
    if (BYP && rf_we && write_reg != 4'd0 && write_reg == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [15:0] exp_busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic check_model();
    check("rsa", rsa, exp_read(read_rega));
    check("rsb", rsb, exp_read(read_regb));
    check("stall", 32'(stall), 32'(exp_port_busy(read_rega) | exp_port_busy(read_regb)));
    check("busy_vec", 32'(busy_vec), 32'(exp_busy_vec()));
  endtask

  // Inputs are applied just after a rising edge; outputs checked mid-cycle.
  task automatic tick();
    #2;
    check_model();
    @(posedge clk);
    if (rst_f) begin
      if (rf_we && write_reg != 4'd0) m_regs[write_reg] = write_data;
      if (rf_we) m_busy[write_reg] = 1'b0;
      if (mark_busy && mark_reg != 4'd0) m_busy[mark_reg] = 1'b1;
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] ra, input logic [3:0] rb, input logic we,
                       input logic [3:0] wr, input logic [31:0] wd,
                       input logic mk, input logic [3:0] mr);
    read_rega  = ra;
    read_regb  = rb;
    rf_we      = we;
    write_reg  = wr;
    write_data = wd;
    mark_busy  = mk;
    mark_reg   = mr;
  endtask

  initial begin
    model_reset();
    rst_f = 1'b0;
    drive(4'd5, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    #1;
    check("reset_rsa", rsa, 32'h0);
    check("reset_busy", 32'(busy_vec), 32'h0);
    #2 rst_f = 1'b1;
    @(posedge clk);
    #1;

    // Load R5 and mark R6, then reset asynchronously between edges
    drive(4'd5, 4'd6, 1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 4'd6);
    tick();
    drive(4'd5, 4'd6, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    #2;
    check("pre_rst_rsa", rsa, 32'hDEADBEEF);
    rst_f = 1'b0;
    #1;
    check("async_rst_rsa", rsa, 32'h0);
    check("async_rst_busy", 32'(busy_vec), 32'h0);
    model_reset();
    drive(4'd5, 4'd6, 1'b1, 4'd5, 32'h11111111, 1'b1, 4'd5);
    @(posedge clk);
    #1;
    check("rst_write_lost", rsa, 32'h0);
    rst_f = 1'b1;
    drive(4'd5, 4'd6, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    tick();

    // R0 discards writes and never goes busy
    drive(4'd0, 4'd0, 1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd0);
    tick();
    drive(4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    #2;
    check("r0_rsa", rsa, 32'h0);
    check("r0_rsb", rsb, 32'h0);
    check("r0_stall", 32'(stall), 32'h0);
    tick();

    // Write then read, with and without bypass
    drive(4'd0, 4'd3, 1'b1, 4'd3, 32'h12345678, 1'b0, 4'd0);
    #2;
    check("wr_pre_rsb", rsb, BYP ? 32'h12345678 : 32'h0);
    tick();
    drive(4'd0, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    #2;
    check("wr_post_rsb", rsb, 32'h12345678);
    tick();

    // Scoreboard set, stall, clear by write
    drive(4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7);
    tick();
    drive(4'd7, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    #2;
    check("sb_stall_set", 32'(stall), 32'h1);
    tick();
    drive(4'd7, 4'd0, 1'b1, 4'd7, 32'h00000042, 1'b0, 4'd0);
    #2;
    check("sb_stall_wr_cycle", 32'(stall), BYP ? 32'h0 : 32'h1);
    tick();
    drive(4'd7, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    #2;
    check("sb_stall_clr", 32'(stall), 32'h0);
    check("sb_rsa", rsa, 32'h00000042);
    tick();

    // Same-register set and clear: set wins
    drive(4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9);
    tick();
    drive(4'd0, 4'd0, 1'b1, 4'd9, 32'hA5A5A5A5, 1'b1, 4'd9);
    tick();
    drive(4'd9, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    #2;
    check("same_busy9", 32'(busy_vec[9]), 32'h1);
    check("same_r9", rsa, 32'hA5A5A5A5);
    tick();
    drive(4'd0, 4'd0, 1'b1, 4'd9, 32'h5A5A5A5A, 1'b1, 4'd10);
    tick();
    #2;
    check("diff_busy9", 32'(busy_vec[9]), 32'h0);
    check("diff_busy10", 32'(busy_vec[10]), 32'h1);
    tick();

    // Dual-port stall with only R2 busy
    drive(4'd0, 4'd0, 1'b1, 4'd10, 32'h0000000A, 1'b1, 4'd2);
    tick();
    drive(4'd4, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    #2;
    check("dual_busy_only2", 32'(busy_vec), 32'h0004);
    check("dual_stall_b", 32'(stall), 32'h1);
    tick();
    drive(4'd4, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    #2;
    check("dual_stall_clear", 32'(stall), 32'h0);
    tick();

    // Random traffic on a narrow address range to force collisions
    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
      if (n % 50 == 49) begin
        read_rega = 4'($urandom_range(8, 15));
        write_reg = read_rega;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
